// File: rtl/video_scanlines.sv
// video_scanlines: CRT-style scanline dimming on a doubled-rate video stream.
module video_scanlines #(
  parameter int HALF_DEPTH = 0,
  localparam int W = HALF_DEPTH ? 3 : 8
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ce_pix,
  input  logic [1:0]   scanlines,
  input  logic         hs_in,
  input  logic         vs_in,
  input  logic         hb_in,
  input  logic         vb_in,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] g_in,
  input  logic [W-1:0] b_in,
  output logic         hs_out,
  output logic         vs_out,
  output logic         hb_out,
  output logic         vb_out,
  output logic [W-1:0] r_out,
  output logic [W-1:0] g_out,
  output logic [W-1:0] b_out
);
  logic hs1, vs1, hb1, vb1, parity, pend, vs_line;
  logic [1:0] mode;
  logic [W-1:0] r1, g1, b1;
  logic line_start, frame_start, blank;
  assign line_start  = hs1 & ~hs_in;
  assign frame_start = ~vs1 & vs_in;
  assign blank       = hb1 | vb1;
  function automatic logic [W-1:0] dim(input logic [W-1:0] c, input logic [1:0] m, input logic odd);
    return (m == 2'd0 || !odd) ? c : m == 2'd1 ? c - (c >> 2) : m == 2'd2 ? c >> 1 : c >> 2;
  endfunction
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {hs1, vs1, r1, g1, b1} <= '0;
      {hb1, vb1} <= 2'b11;
      {parity, pend, vs_line, mode} <= '0;
      {hs_out, vs_out, r_out, g_out, b_out} <= '0;
      {hb_out, vb_out} <= 2'b11;
    end else if (ce_pix) begin
      {hs1, vs1, hb1, vb1} <= {hs_in, vs_in, hb_in, vb_in};
      {r1, g1, b1} <= {r_in, g_in, b_in};
      {hs_out, hb_out, vb_out} <= {hs1, hb1, vb1};
      r_out <= blank ? '0 : dim(r1, mode, parity);
      g_out <= blank ? '0 : dim(g1, mode, parity);
      b_out <= blank ? '0 : dim(b1, mode, parity);
      if (frame_start) mode <= scanlines;
      // a pending frame start forces the first line of the frame to be even
      if (line_start) begin
        parity  <= (pend | frame_start) ? 1'b0 : ~parity;
        pend    <= 1'b0;
        vs_line <= vs_in;
        vs_out  <= vs_line;
      end else if (frame_start) pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_scanlines.sv
// tb_video_scanlines: scoreboard bench for scanline dimming, sync delay and reset.
module tb_video_scanlines;
  logic clk_sys = 1'b0;
  logic reset = 1'b0, ce_pix = 1'b0;
  logic [1:0] scanlines = 2'd0;
  logic hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic hs_out, vs_out, hb_out, vb_out;
  logic [7:0] r_out, g_out, b_out;
  typedef struct packed {logic hs; logic hb; logic vb; logic [7:0] r; logic [7:0] g; logic [7:0] b;} px_t;
  px_t sb[$];
  int checks = 0, errors = 0, div = 1;
  logic [1:0] md_exp = 2'd0;
  logic exp_vs = 1'b0, vs_ls = 1'b0, first = 1'b1;
  always #5 clk_sys = ~clk_sys;
  video_scanlines dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .scanlines(scanlines),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] dim(input logic [7:0] c, input logic [1:0] m, input logic odd);
    if (m == 2'd0 || !odd) return c;
    if (m == 2'd1) return c - (c >> 2);
    if (m == 2'd2) return c >> 1;
    return c >> 2;
  endfunction
  function automatic logic [27:0] outs();
    return {hs_out, hb_out, vb_out, r_out, g_out, b_out, vs_out};
  endfunction
  task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic odd);
    px_t e;
    logic [27:0] snap;
    {hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in} = {hs, vs, hb, vb, r, g, b};
    e.hs = hs; e.hb = hb; e.vb = vb;
    e.r = (hb | vb) ? 8'h00 : dim(r, md_exp, odd);
    e.g = (hb | vb) ? 8'h00 : dim(g, md_exp, odd);
    e.b = (hb | vb) ? 8'h00 : dim(b, md_exp, odd);
    sb.push_back(e);
    ce_pix = 1'b1;
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("pix", 32'({hs_out, hb_out, vb_out, r_out, g_out, b_out}), 32'(e));
    end
    check("vs_out", 32'(vs_out), 32'(exp_vs));
    snap = outs();
    for (int k = 1; k < div; k++) begin
      @(posedge clk_sys); #1;
      check("hold", 32'(outs()), 32'(snap));
    end
  endtask
  // pixels 0-4 active, 5 hblank, 6-7 hsync; vs changes only at pixels 0 and 5
  task automatic line(input logic va, input logic vb_s, input logic vbl, input logic odd,
                      input logic [7:0] c, input int n = 8);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        if (!first) begin
          exp_vs = vs_ls;
          vs_ls  = va;
        end
        first = 1'b0;
      end
      pix(i >= 6, i < 5 ? va : vb_s, i >= 5, vbl, c, c + 8'(i * 17), ~c, odd);
      if (i == 5 && vb_s && !va) md_exp = scanlines;
    end
  endtask
  task automatic frame(input logic [7:0] c, input logic [1:0] nsc);
    for (int j = 0; j < 5; j++) begin
      if (j == 2) scanlines = nsc;
      line(j <= 1, j == 0 || j == 4, j == 4, j[0], c);
    end
  endtask
  task automatic do_reset(input logic ce);
    reset = 1'b1; ce_pix = ce;
    @(posedge clk_sys); #1;
    reset = 1'b0; ce_pix = 1'b0;
    check("rst", 32'({hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out}), 32'({4'b0011, 24'h0}));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_sys); #1;
      check("rst_hold", 32'({hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out}), 32'({4'b0011, 24'h0}));
    end
    sb.delete();
    sb.push_back(px_t'({3'b011, 24'h0}));
    first = 1'b1; exp_vs = 1'b0; vs_ls = 1'b0; md_exp = 2'd0;
  endtask
  initial begin
    do_reset(1'b0);
    scanlines = 2'd2;
    line(1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
    frame(8'hC8, 2'd1);
    frame(8'hFF, 2'd3);
    frame(8'hFF, 2'd0);
    frame(8'hA5, 2'd3);
    div = 4;
    frame(8'hA5, 2'd2);
    line(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 3);
    do_reset(1'b1);
    scanlines = 2'd3;
    line(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    frame(8'h3C, 2'd1);
    div = 1;
    frame(8'hE7, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
